// File: rtl/instruction_fetch.sv
// Fetch front end: drives the program-memory address, absorbs its 1-cycle read latency
// and hands instructions to decode over valid/ready, with branch redirect and halt.
module instruction_fetch #(
  parameter int          ADDR_W     = 11,
  parameter int          DATA_W     = 16,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                accept;
  logic                issue;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    accept = !instr_valid_q || instr_ready;
    // A new read may launch whenever the word it will produce has a place to land:
    // either the output frees up this edge, or both the output path and skid are idle.
    issue  = (state_q == RUN) && !halt && !branch_en &&
             (accept || (!skid_valid_q && !inflight_q));

    if (state_q == RUN) begin
      if (halt) begin
        state_d       = HALTED;
        skid_valid_d  = 1'b0;
        instr_valid_d = 1'b0;
      end else if (branch_en) begin
        pc_d          = branch_target;
        skid_valid_d  = 1'b0;
        instr_valid_d = 1'b0;
      end else begin
        if (issue) begin
          inflight_d    = 1'b1;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + ADDR_W'(1);
        end

        if (skid_valid_q && accept) begin
          instr_d       = skid_data_q;
          instr_pc_d    = skid_pc_q;
          instr_valid_d = 1'b1;
          skid_valid_d  = 1'b0;
        end else if (inflight_q && accept) begin
          instr_d       = mem_data;
          instr_pc_d    = inflight_pc_q;
          instr_valid_d = 1'b1;
        end else if (inflight_q) begin
          skid_data_d   = mem_data;
          skid_pc_d     = inflight_pc_q;
          skid_valid_d  = 1'b1;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= ADDR_W'(RESET_ADDR);
      inflight_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      skid_valid_q  <= skid_valid_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Payload-only registers; their contents are qualified by inflight_q / skid_valid_q.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    skid_data_q   <= skid_data_d;
    skid_pc_q     <= skid_pc_d;
  end

  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == HALTED);

endmodule
